prog_counter: RTL and testbench

PROG_COUNTER -- requirements
Module: prog_counter

---
 rtl/prog_counter_pkg.sv | 14 +
 rtl/prog_counter_tick_gen.sv | 35 +++
 rtl/prog_counter.sv | 100 ++++++++++
 tb/tb_prog_counter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_counter_pkg.sv
// Shared enums for the programmable counter: count mode and count direction.
package prog_counter_pkg;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

endpackage

// File: rtl/prog_counter_tick_gen.sv
// Prescaler: counts enabled cycles and issues a tick on the edge where it
// reaches (or already exceeds) the programmed period, then restarts from 0.
module tick_gen #(
   parameter int PRESC_BITS = 4
) (
   input  logic                  clock_i,
   input  logic                  resetb_i,
   input  logic                  enable_i,
   input  logic                  restart_i,
   input  logic [PRESC_BITS-1:0] period_i,
   output logic                  tick_o
);

   logic [PRESC_BITS-1:0] presc_cnt;
   logic                  at_period;

   // >= so that lowering period_i below the current count still ticks next cycle
   assign at_period = (presc_cnt >= period_i);
   assign tick_o    = enable_i & ~restart_i & at_period;

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         presc_cnt <= '0;
      end else if (restart_i) begin
         presc_cnt <= '0;
      end else if (enable_i) begin
         if (at_period) begin
            presc_cnt <= '0;
         end else begin
            presc_cnt <= presc_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaler, wrap/saturate modes,
// terminal-count pulse and sticky overflow flag.
module prog_counter
   import prog_counter_pkg::*;
#(
   parameter int NB_BITS    = 4,
   parameter int PRESC_BITS = 4
) (
   input  logic                  clock_i,
   input  logic                  resetb_i,
   input  logic                  enable_i,
   input  logic                  clear_i,
   input  logic                  load_i,
   input  logic [NB_BITS-1:0]    load_val_i,
   input  logic                  dir_i,
   input  logic                  mode_i,
   input  logic [NB_BITS-1:0]    max_i,
   input  logic [PRESC_BITS-1:0] presc_i,
   input  logic                  ovf_clr_i,
   output logic [NB_BITS-1:0]    count_o,
   output logic                  tc_o,
   output logic                  ovf_o
);

   logic               restart;
   logic               step;
   logic               term;
   logic [NB_BITS-1:0] next_count;

   // Returns {terminal, next count} for one step from cnt.
   function automatic logic [NB_BITS:0] step_count(
      input logic [NB_BITS-1:0] cnt,
      input logic [NB_BITS-1:0] max,
      input dir_e               dir,
      input mode_e              mode
   );
      logic               t;
      logic [NB_BITS-1:0] n;
      t = 1'b0;
      n = cnt;
      if (dir == DIR_UP) begin
         if (cnt < max) begin
            n = cnt + 1'b1;
         end else begin
            t = 1'b1;
            n = (mode == MODE_SAT) ? max : '0;
         end
      end else begin
         if (cnt != '0) begin
            n = cnt - 1'b1;
         end else begin
            t = 1'b1;
            n = (mode == MODE_SAT) ? '0 : max;
         end
      end
      return {t, n};
   endfunction

   // Clear and load both restart the prescaler and suppress the step.
   assign restart = clear_i | load_i;

   tick_gen #(
      .PRESC_BITS (PRESC_BITS)
   ) u_tick_gen (
      .clock_i   (clock_i),
      .resetb_i  (resetb_i),
      .enable_i  (enable_i),
      .restart_i (restart),
      .period_i  (presc_i),
      .tick_o    (step)
   );

   always_comb begin
      {term, next_count} = step_count(count_o, max_i, dir_e'(dir_i), mode_e'(mode_i));
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         count_o <= '0;
         tc_o    <= 1'b0;
         ovf_o   <= 1'b0;
      end else begin
         if (clear_i) begin
            count_o <= '0;
         end else if (load_i) begin
            count_o <= load_val_i;
         end else if (step) begin
            count_o <= next_count;
         end
         tc_o <= step & term;
         // A terminal event outranks a simultaneous flag clear
         if (step && term) begin
            ovf_o <= 1'b1;
         end else if (ovf_clr_i) begin
            ovf_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: behavioural model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_prog_counter;

   localparam int NB = 4;
   localparam int PB = 4;

   logic          clock_i = 1'b0;
   logic          resetb_i;
   logic          enable_i, clear_i, load_i, dir_i, mode_i, ovf_clr_i;
   logic [NB-1:0] load_val_i, max_i;
   logic [PB-1:0] presc_i;
   logic [NB-1:0] count_o;
   logic          tc_o, ovf_o;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // model state
   int m_cnt = 0;
   int m_pre = 0;
   int m_tc  = 0;
   int m_ovf = 0;

   prog_counter #(.NB_BITS(NB), .PRESC_BITS(PB)) dut (
      .clock_i    (clock_i),
      .resetb_i   (resetb_i),
      .enable_i   (enable_i),
      .clear_i    (clear_i),
      .load_i     (load_i),
      .load_val_i (load_val_i),
      .dir_i      (dir_i),
      .mode_i     (mode_i),
      .max_i      (max_i),
      .presc_i    (presc_i),
      .ovf_clr_i  (ovf_clr_i),
      .count_o    (count_o),
      .tc_o       (tc_o),
      .ovf_o      (ovf_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
      end
   endtask

   // Model: what the counter must hold after each edge, from the rules directly.
   always @(negedge resetb_i) begin
      m_cnt = 0; m_pre = 0; m_tc = 0; m_ovf = 0;
   end

   always @(posedge clock_i) begin
      if (resetb_i === 1'b1) begin
         int  mx, c;
         bit  stepping, terminal;
         mx = int'(max_i);
         c  = m_cnt;
         stepping = 0;
         terminal = 0;
         if (clear_i) begin
            c = 0; m_pre = 0;
         end else if (load_i) begin
            c = int'(load_val_i); m_pre = 0;
         end else if (enable_i) begin
            if (m_pre >= int'(presc_i)) begin
               m_pre = 0; stepping = 1;
            end else begin
               m_pre = m_pre + 1;
            end
         end
         if (stepping) begin
            if (dir_i) begin
               if (c < mx) c = c + 1;
               else begin terminal = 1; c = mode_i ? mx : 0; end
            end else begin
               if (c > 0) c = c - 1;
               else begin terminal = 1; c = mode_i ? 0 : mx; end
            end
         end
         m_cnt = c;
         m_tc  = terminal ? 1 : 0;
         if (terminal) m_ovf = 1;
         else if (ovf_clr_i) m_ovf = 0;
      end
   end

   // Compare process: outputs are stable around the falling edge.
   always @(negedge clock_i) begin
      if (chk_en) begin
         check("model_count", 32'(count_o), 32'(m_cnt));
         check("model_tc",    32'(tc_o),    32'(m_tc));
         check("model_ovf",   32'(ovf_o),   32'(m_ovf));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock_i);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetb_i = 1'b0; enable_i = 0; clear_i = 0; load_i = 0; dir_i = 0;
      mode_i = 0; ovf_clr_i = 0; load_val_i = '0; max_i = '0; presc_i = '0;
      chk_en = 1'b1;
      tick(2);
      check("reset_count", 32'(count_o), 0);
      check("reset_tc",    32'(tc_o),    0);
      check("reset_ovf",   32'(ovf_o),   0);

      // up, wrap, max 9, presc 0
      resetb_i = 1'b1; dir_i = 1; mode_i = 0; max_i = 4'd9; presc_i = 4'd0; enable_i = 1;
      tick(9);
      check("up_reach9", 32'(count_o), 9);
      check("up_tc_pre", 32'(tc_o), 0);
      tick(1);
      check("up_wrap0",  32'(count_o), 0);
      check("up_wrap_tc", 32'(tc_o), 1);
      check("up_wrap_ovf", 32'(ovf_o), 1);
      tick(1);
      check("up_after1", 32'(count_o), 1);
      check("up_tc_drop", 32'(tc_o), 0);
      enable_i = 0; ovf_clr_i = 1;
      tick(1);
      check("ovf_cleared", 32'(ovf_o), 0);
      check("hold_disabled", 32'(count_o), 1);
      ovf_clr_i = 0;

      // down, saturate, presc 2, from load 2
      load_i = 1; load_val_i = 4'd2; dir_i = 0; mode_i = 1; presc_i = 4'd2;
      tick(1);
      check("load2", 32'(count_o), 2);
      load_i = 0; enable_i = 1;
      tick(2);
      check("dn_hold2", 32'(count_o), 2);
      tick(1);
      check("dn_1", 32'(count_o), 1);
      tick(3);
      check("dn_0", 32'(count_o), 0);
      check("dn_0_tc", 32'(tc_o), 0);
      tick(3);
      check("sat_hold0", 32'(count_o), 0);
      check("sat_tc1", 32'(tc_o), 1);
      check("sat_ovf", 32'(ovf_o), 1);
      tick(1);
      check("sat_tc_drop", 32'(tc_o), 0);
      tick(2);
      check("sat_tc2", 32'(tc_o), 1);

      // load above max
      enable_i = 0; load_i = 1; load_val_i = 4'd12; max_i = 4'd9; dir_i = 1; mode_i = 0;
      presc_i = 4'd0; ovf_clr_i = 1;
      tick(1);
      check("load12", 32'(count_o), 12);
      check("ovf_clr2", 32'(ovf_o), 0);
      load_i = 0; ovf_clr_i = 0; enable_i = 1;
      tick(1);
      check("over_up_0", 32'(count_o), 0);
      check("over_up_tc", 32'(tc_o), 1);
      enable_i = 0; load_i = 1;
      tick(1);
      load_i = 0; dir_i = 0; enable_i = 1;
      tick(1);
      check("over_dn_11", 32'(count_o), 11);
      check("over_dn_tc", 32'(tc_o), 0);

      // clear/load on a terminal step edge, then ovf clear vs terminal
      enable_i = 0; ovf_clr_i = 1;
      tick(1);
      ovf_clr_i = 0; load_i = 1; load_val_i = 4'd9; dir_i = 1;
      tick(1);
      check("load9", 32'(count_o), 9);
      clear_i = 1; load_i = 1; load_val_i = 4'd5; enable_i = 1;
      tick(1);
      check("clr_count", 32'(count_o), 0);
      check("clr_tc", 32'(tc_o), 0);
      check("clr_ovf", 32'(ovf_o), 0);
      clear_i = 0; load_val_i = 4'd9;
      tick(1);
      load_i = 0; ovf_clr_i = 1;
      tick(1);
      check("setwins_cnt", 32'(count_o), 0);
      check("setwins_tc", 32'(tc_o), 1);
      check("setwins_ovf", 32'(ovf_o), 1);
      ovf_clr_i = 0;

      // prescaler restarts on clear
      presc_i = 4'd2;
      tick(1);
      clear_i = 1;
      tick(1);
      clear_i = 0;
      tick(2);
      check("presc_restart_hold", 32'(count_o), 0);
      tick(1);
      check("presc_restart_step", 32'(count_o), 1);

      // lowering presc below the running prescale count
      presc_i = 4'd6;
      tick(4);
      check("presc_hi_hold", 32'(count_o), 1);
      presc_i = 4'd1;
      tick(1);
      check("presc_lowered", 32'(count_o), 2);
      tick(2);
      check("presc_new_rate", 32'(count_o), 3);

      // max 0: every step is terminal at 0
      presc_i = 4'd0; clear_i = 1;
      tick(1);
      clear_i = 0; max_i = 4'd0;
      tick(1);
      check("max0_up", 32'(count_o), 0);
      check("max0_up_tc", 32'(tc_o), 1);
      mode_i = 1; dir_i = 0;
      tick(1);
      check("max0_dn_tc", 32'(tc_o), 1);

      // mixed traffic against the model
      for (int i = 0; i < 300; i++) begin
         enable_i   = ($urandom_range(0, 3) != 0);
         clear_i    = ($urandom_range(0, 19) == 0);
         load_i     = ($urandom_range(0, 19) == 0);
         ovf_clr_i  = ($urandom_range(0, 9) == 0);
         dir_i      = ($urandom_range(0, 1) != 0);
         mode_i     = ($urandom_range(0, 1) != 0);
         max_i      = NB'($urandom_range(0, 15));
         load_val_i = NB'($urandom_range(0, 15));
         presc_i    = PB'($urandom_range(0, 3));
         tick(1);
      end

      // asynchronous reset mid-count
      enable_i = 1; clear_i = 1; load_i = 0; ovf_clr_i = 0; dir_i = 1; mode_i = 0;
      max_i = 4'd9; presc_i = 4'd0;
      tick(1);
      clear_i = 0;
      tick(5);
      check("pre_rst_count", 32'(count_o), 5);
      presc_i = 4'd3;
      @(posedge clock_i);
      #2 resetb_i = 1'b0;
      #1;
      check("async_rst_count", 32'(count_o), 0);
      check("async_rst_tc",    32'(tc_o),    0);
      check("async_rst_ovf",   32'(ovf_o),   0);
      tick(1);
      resetb_i = 1'b1;
      tick(3);
      check("post_rst_hold", 32'(count_o), 0);
      tick(1);
      check("post_rst_step", 32'(count_o), 1);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
